// File: rtl/mat_pkg.sv
// mat_pkg: definitions shared by the matrix stream unpacker.
//   - mat_state_e  : frame FSM states (IDLE/RUN/DONE)
//   - MK_*         : bit positions of the sof/eol/eof markers in the side band
//                    that travels with each pixel through the optional skid buffer
//   - pix_per_word : number of pixels carried by one FIFO word
package mat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mat_state_e;

    localparam int MK_SOF = 0;
    localparam int MK_EOL = 1;
    localparam int MK_EOF = 2;
    localparam int MK_W   = 3;

    // Clamped to 1 so a mis-set width pair cannot produce a zero-lane buffer.
    function automatic int pix_per_word(input int in_w, input int pix_w);
        return ((in_w / pix_w) < 1) ? 1 : (in_w / pix_w);
    endfunction

endpackage

// File: rtl/mat_skid_buf.sv
// mat_skid_buf: 2-entry valid/ready register slice.
// The upstream ready is a register output, which breaks the combinational
// path from m_ready back into the producer. Full throughput is kept: the
// second entry absorbs the beat already in flight when the sink stalls.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid    upstream beat,   s_ready upstream accept
//   m_data/m_valid    downstream beat, m_ready downstream accept
module mat_skid_buf #(
    parameter int c_WIDTH = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_WIDTH-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [c_WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready
);

    logic [c_WIDTH-1:0] out_q;
    logic [c_WIDTH-1:0] skid_q;
    logic               out_v;
    logic               skid_v;

    assign s_ready = ~skid_v;
    assign m_data  = out_q;
    assign m_valid = out_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (~out_v | m_ready) begin
            // Output slot free or draining: refill from the skid entry first.
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                out_q  <= s_data;
                out_v  <= s_valid;
            end
        end else if (s_valid & ~skid_v) begin
            // Stalled: park the beat that was accepted under the old ready.
            skid_q <= s_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/mat_stream_unpack.sv
// mat_stream_unpack: pops packed words from a first-word-fall-through matrix
// FIFO and emits one pixel per beat (LSB lane first) on a valid/ready stream,
// tagged with start-of-frame, end-of-line and end-of-frame markers for a
// geometry latched at start.
// Ports:
//   clk, rst                      clock (FIFO read domain), sync active-high reset
//   start, cfg_cols, cfg_rows     frame launch and geometry (cols multiple of
//                                 pixels per word)
//   busy, done                    frame in progress / one-cycle end pulse
//   fifo_rd_data/vld, fifo_rd_en  FIFO head word and pop
//   m_data, m_valid, m_ready      pixel stream
//   m_sof, m_eol, m_eof           markers, qualified by m_valid
// Build option: MAT_UNPACK_SKID_EN routes the pixel stream through a 2-entry
// skid buffer so fifo_rd_en no longer depends combinationally on m_ready
// (+1 cycle latency, same throughput).
module mat_stream_unpack
    import mat_pkg::*;
#(
    parameter int c_IN_WIDTH  = 32,
    parameter int c_PIX_WIDTH = 8,
    parameter int c_COL_WIDTH = 12,
    parameter int c_ROW_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [c_COL_WIDTH-1:0] cfg_cols,
    input  logic [c_ROW_WIDTH-1:0] cfg_rows,
    output logic                   busy,
    output logic                   done,
    input  logic [c_IN_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_vld,
    output logic                   fifo_rd_en,
    output logic [c_PIX_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof
);

    localparam int PPW    = pix_per_word(c_IN_WIDTH, c_PIX_WIDTH);
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WL_W   = c_COL_WIDTH + c_ROW_WIDTH;

    localparam logic [LANE_W-1:0]      LANE_LAST = LANE_W'(PPW - 1);
    localparam logic [LANE_W-1:0]      LANE_ONE  = LANE_W'(1);
    localparam logic [c_COL_WIDTH-1:0] COL_ONE   = c_COL_WIDTH'(1);
    localparam logic [c_ROW_WIDTH-1:0] ROW_ONE   = c_ROW_WIDTH'(1);
    localparam logic [WL_W-1:0]        WL_ONE    = WL_W'(1);

    mat_state_e state;

    logic [c_COL_WIDTH-1:0] cols_q;
    logic [c_ROW_WIDTH-1:0] rows_q;
    logic [c_COL_WIDTH-1:0] col;
    logic [c_ROW_WIDTH-1:0] row;
    logic [WL_W-1:0]        words_left;

    logic [c_IN_WIDTH-1:0]  word_buf;
    logic [LANE_W-1:0]      lane;
    logic                   buf_full;

    logic [PPW-1:0][c_PIX_WIDTH-1:0] lanes;
    logic [c_PIX_WIDTH-1:0]          px_data;
    logic [MK_W-1:0]                 px_mk;
    logic                            px_ready;
    logic                            hs;
    logic                            last_lane;
    logic                            pop;
    logic                            accept;
    logic                            frame_end;

    assign accept    = (state == ST_IDLE) & start;
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    assign lanes     = word_buf;
    assign px_data   = lanes[lane];
    assign last_lane = (lane == LANE_LAST);
    assign hs        = buf_full & px_ready;

    // Markers are zero whenever no pixel is presented.
    assign px_mk[MK_SOF] = buf_full & (col == '0) & (row == '0);
    assign px_mk[MK_EOL] = buf_full & (col == cols_q - COL_ONE);
    assign px_mk[MK_EOF] = px_mk[MK_EOL] & (row == rows_q - ROW_ONE);

    // Refill either into an empty buffer or in the same cycle the last lane
    // leaves, so back-to-back words stream without a bubble.
    assign pop = busy & ~rst & fifo_rd_vld & (words_left != '0)
               & (~buf_full | (hs & last_lane));
    assign fifo_rd_en = pop;

`ifdef MAT_UNPACK_SKID_EN
    logic [c_PIX_WIDTH+MK_W-1:0] sk_data;
    logic                        sk_valid;

    mat_skid_buf #(
        .c_WIDTH(c_PIX_WIDTH + MK_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({px_data, px_mk}),
        .s_valid (buf_full),
        .s_ready (px_ready),
        .m_data  (sk_data),
        .m_valid (sk_valid),
        .m_ready (m_ready)
    );

    assign m_valid = sk_valid;
    assign m_data  = sk_data[MK_W +: c_PIX_WIDTH];
    assign m_sof   = sk_valid & sk_data[MK_SOF];
    assign m_eol   = sk_valid & sk_data[MK_EOL];
    assign m_eof   = sk_valid & sk_data[MK_EOF];
`else
    assign px_ready = m_ready;
    assign m_valid  = buf_full;
    assign m_data   = px_data;
    assign m_sof    = px_mk[MK_SOF];
    assign m_eol    = px_mk[MK_EOL];
    assign m_eof    = px_mk[MK_EOF];
`endif

    // The frame ends on the sink's handshake of the eof beat, so with the
    // skid buffer enabled done waits for the buffer to drain.
    assign frame_end = m_valid & m_ready & m_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cols_q <= '0;
            rows_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    cols_q <= cfg_cols;
                    rows_q <= cfg_rows;
                    state  <= ((cfg_cols == '0) || (cfg_rows == '0)) ? ST_DONE : ST_RUN;
                end
                ST_RUN:  if (frame_end) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_buf   <= '0;
            lane       <= '0;
            buf_full   <= 1'b0;
            col        <= '0;
            row        <= '0;
            words_left <= '0;
        end else if (accept) begin
            lane       <= '0;
            buf_full   <= 1'b0;
            col        <= '0;
            row        <= '0;
            words_left <= WL_W'(cfg_cols / c_COL_WIDTH'(PPW)) * WL_W'(cfg_rows);
        end else begin
            if (pop) begin
                word_buf   <= fifo_rd_data;
                buf_full   <= 1'b1;
                lane       <= '0;
                words_left <= words_left - WL_ONE;
            end else if (hs & last_lane) begin
                buf_full   <= 1'b0;
                lane       <= '0;
            end else if (hs) begin
                lane       <= lane + LANE_ONE;
            end

            if (hs) begin
                if (col == cols_q - COL_ONE) begin
                    col <= '0;
                    row <= row + ROW_ONE;
                end else begin
                    col <= col + COL_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_stream_unpack.sv
// Self-checking bench for mat_stream_unpack: randomised frames, a FIFO model,
// and a scoreboard of expected beats built from the frame geometry.
module tb_mat_stream_unpack;

    localparam int IW  = 32;
    localparam int PW  = 8;
    localparam int CW  = 12;
    localparam int RW  = 12;
    localparam int PPW = IW / PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_cols = '0;
    logic [RW-1:0] cfg_rows = '0;
    logic          busy, done;
    logic [IW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_vld = 1'b0;
    logic          fifo_rd_en;
    logic [PW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_sof, m_eol, m_eof;

    mat_stream_unpack #(
        .c_IN_WIDTH(IW), .c_PIX_WIDTH(PW), .c_COL_WIDTH(CW), .c_ROW_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .busy(busy), .done(done),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t         exp_q[$];
    logic [IW-1:0] fifo_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int beat_cnt = 0;
    int last_eof_cyc = -10;
    int ready_mode = 0;
    int starve_cnt = 0;
    bit rand_gap = 0;
    bit pop_seen = 0;
    bit frame_nz = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // FIFO model and sink: apply the pop seen in the previous cycle, then
    // present the new head and ready just after the edge.
    initial begin
        bit gap;
        forever begin
            @(posedge clk);
            cyc++;
            if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
            #1;
            gap = (starve_cnt > 0) || (rand_gap && $urandom_range(0, 3) == 0);
            if (starve_cnt > 0) starve_cnt--;
            fifo_rd_vld  = (fifo_q.size() != 0) && !gap;
            fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard compare on every handshake, stall stability,
    // pop legality and done latency.
    initial begin
        beat_t cur, prev, e;
        bit    prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            pop_seen = 0;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (fifo_rd_en) chk("rd_en_without_vld", fifo_rd_vld, 1);
                pop_seen = fifo_rd_vld & fifo_rd_en;
                if (pop_seen) pop_cnt++;
                cur = '{data: m_data, sof: m_sof, eol: m_eol, eof: m_eof};
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_hold", cur, prev);
                end
                if (m_valid && m_ready) begin
                    beat_cnt++;
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("beat", cur, e);
                    end
                    if (m_eof) last_eof_cyc = cyc;
                end
                if (done && frame_nz) chk("done_latency", cyc, last_eof_cyc + 1);
                prev_stall = m_valid & ~m_ready;
                prev = cur;
            end
        end
    end

    task automatic do_reset(input bit flush);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rd_en_during_rst", fifo_rd_en, 0);
        if (flush) begin
            exp_q.delete();
            fifo_q.delete();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_markers", {m_sof, m_eol, m_eof}, 0);
        chk("post_rst_rd_en", fifo_rd_en, 0);
        chk("post_rst_data", m_data, 0);
    endtask

    // Loads the FIFO, builds the expected beat list and pulses start;
    // returns at the sampling point of cycle 1 (start was in cycle 0).
    task automatic setup_frame(input int cols, input int rows, input int extra,
                               input int rmode, input bit seq, input bit gaps,
                               input bit chk_pop, output logic [IW-1:0] head_after);
        logic [IW-1:0] words[$];
        logic [IW-1:0] w;
        beat_t         b;
        int            nw, np;
        np = cols * rows;
        nw = np / PPW;
        @(negedge clk);
        ready_mode = rmode;
        rand_gap   = gaps;
        for (int i = 0; i < nw + extra; i++) begin
            w = seq ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : IW'($urandom);
            fifo_q.push_back(w);
            words.push_back(w);
        end
        head_after = (extra > 0) ? words[nw] : '0;
        for (int i = 0; i < np; i++) begin
            b.data = PW'(words[i / PPW] >> (PW * (i % PPW)));
            b.sof  = (i == 0);
            b.eol  = ((i % cols) == cols - 1);
            b.eof  = (i == np - 1);
            exp_q.push_back(b);
        end
        pop_cnt = 0;
        beat_cnt = 0;
        frame_nz = (np != 0);
        last_eof_cyc = -10;
        @(posedge clk); #1;
        cfg_cols = CW'(cols);
        cfg_rows = RW'(rows);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_cols = CW'($urandom);
        cfg_rows = RW'($urandom);
        @(negedge clk);
        if (np == 0) begin
            chk("zero_done_c1", done, 1);
            chk("zero_busy_c1", busy, 0);
        end else begin
            chk("busy_c1", busy, 1);
            if (chk_pop) chk("pop_c1", fifo_rd_en, 1);
        end
    endtask

    task automatic run_frame(input int cols, input int rows, input int extra,
                             input int rmode, input bit seq, input bit gaps,
                             input int starve_at, input bit dup_start, input bit chk_lat);
        logic [IW-1:0] head;
        int            n;
        bit            starved;
        starved = 0;
        setup_frame(cols, rows, extra, rmode, seq, gaps, chk_lat, head);
        if (chk_lat) begin
            @(negedge clk);
`ifdef MAT_UNPACK_SKID_EN
            chk("valid_c2_skid", m_valid, 0);
            @(negedge clk);
`endif
            chk("first_valid", m_valid, 1);
        end
        n = 0;
        while (!done && n < 4000) begin
            if (dup_start && n == 3) begin
                // A second start mid-frame with zero geometry must be ignored.
                @(posedge clk); #1;
                cfg_cols = '0;
                cfg_rows = '0;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (starve_at > 0 && !starved && beat_cnt >= starve_at) begin
                starve_cnt = 5;
                starved = 1;
            end
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("pop_count", pop_cnt, (cols * rows) / PPW);
        chk("beats_left", exp_q.size(), 0);
        chk("fifo_left", fifo_q.size(), extra);
        if (extra > 0 && fifo_q.size() != 0) chk("fifo_head", fifo_q[0], head);
        @(negedge clk);
        chk("done_pulse", done, 0);
        fifo_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [IW-1:0] head;
        int n;
        do_reset(1);
        // Basic frame, full-rate sink, latency checks.
        run_frame(8, 2, 0, 0, 1, 0, 0, 0, 1);
        // Backpressure 1,0,0,1.
        run_frame(8, 2, 0, 1, 1, 0, 0, 0, 0);
        // Starved FIFO mid-line.
        run_frame(16, 2, 0, 0, 0, 0, 6, 0, 0);
        // Over-supply: 6 words for a 4-word frame.
        run_frame(8, 2, 2, 0, 1, 0, 0, 0, 0);
        // Zero geometry.
        run_frame(0, 3, 0, 0, 0, 0, 0, 0, 0);
        run_frame(8, 0, 0, 0, 0, 0, 0, 0, 0);
        // Start during RUN is ignored.
        run_frame(16, 4, 0, 2, 0, 1, 0, 1, 0);
        // Randomised geometry, sink and FIFO gaps.
        for (int k = 0; k < 6; k++)
            run_frame(4 * $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 2),
                      2, 0, 1, 0, 0, 0);
        // Mid-frame reset at beat 5, then a fresh frame.
        setup_frame(16, 2, 0, 0, 0, 0, 0, head);
        n = 0;
        while (beat_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_beat5", beat_cnt >= 5, 1);
        do_reset(1);
        run_frame(8, 1, 0, 2, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
